// File: rtl/vlsu_pkg.sv
`default_nettype none
//============================================================================
// Module      : vlsu_pkg
// Description : Shared types and helpers for the multi-requester VLSU
//               control machine: FSM encoding, burst metadata record and
//               the burst-length computation.
// Revision    : 1.0 - initial release
//============================================================================
package vlsu_pkg;

    localparam int unsigned PAGE_BYTES      = 4096;
    localparam int unsigned MAX_BURST_LIMIT = 256;
    localparam int unsigned META_SRC_W      = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic [META_SRC_W-1:0] src;
        logic                  write;
        logic [8:0]            beats;
        logic                  last;
    } meta_t;

    // Largest legal burst: limited by what is left, the AXI burst cap and
    // the distance to the next 4 KiB page boundary.
    function automatic logic [8:0] burst_len(
        input logic [31:0] remaining,
        input logic [11:0] addr_lo,
        input int unsigned beat_bytes,
        input int unsigned max_beats
    );
        logic [31:0] page_beats;
        logic [31:0] lim;
        page_beats = (32'(PAGE_BYTES) - {20'd0, addr_lo}) / beat_bytes;
        lim = remaining;
        if (32'(max_beats) < lim) lim = 32'(max_beats);
        if (page_beats < lim)     lim = page_beats;
        return lim[8:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/vlsu_meta_fifo.sv
`default_nettype none
//============================================================================
// Module      : vlsu_meta_fifo
// Description : Small power-of-two deep FIFO carrying per-burst metadata
//               from the AX issue side to the data controller.
// Revision    : 1.0 - initial release
//============================================================================
module vlsu_meta_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  T     data_i,
    output logic full_o,
    input  logic pop_i,
    output logic valid_o,
    output T     data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             w_push;
    logic             w_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer/count update; a push into a full FIFO only lands when the head leaves the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        w_pop    = pop_i && valid_o;
        w_push   = push_i && (!full_o || w_pop);
        if (w_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vlsu_ctrl_machine_mc.sv
`default_nettype none
//============================================================================
// Module      : vlsu_ctrl_machine_mc
// Description : Round-robin arbitration of vector memory requests, split
//               into AXI bursts (burst cap and 4 KiB boundaries), metadata
//               FIFO for the data controller and store B-response tracking.
//               Optional macro VLSU_CTRL_LDST_ORDER_EN holds loads back
//               while any store is outstanding or being issued.
// Revision    : 1.0 - initial release
//============================================================================
module vlsu_ctrl_machine_mc
    import vlsu_pkg::*;
#(
    parameter int unsigned NR_REQ          = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned BEATS_WIDTH     = 16,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned MAX_BURST_BEATS = 256,
    parameter int unsigned META_DEPTH      = 4,
    parameter int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned SRC_W          = (NR_REQ > 1) ? $clog2(NR_REQ) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NR_REQ-1:0]             req_valid_i,
    output logic [NR_REQ-1:0]             req_ready_o,
    input  logic [NR_REQ-1:0]             req_store_i,
    input  logic [NR_REQ*ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NR_REQ*BEATS_WIDTH-1:0] req_beats_i,
    output logic                          ax_valid_o,
    input  logic                          ax_ready_i,
    output logic                          ax_write_o,
    output logic [ADDR_WIDTH-1:0]         ax_addr_o,
    output logic [7:0]                    ax_len_o,
    output logic [SRC_W-1:0]              ax_src_o,
    output logic                          meta_valid_o,
    input  logic                          meta_ready_i,
    output meta_t                         meta_o,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    output logic                          st_pending_o,
    output logic                          busy_o
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned OUT_W      = $clog2(MAX_OUTSTANDING + 1);

    state_e                 state_q, state_d;
    logic [SRC_W-1:0]       ptr_q, ptr_d;
    logic [SRC_W-1:0]       src_q, src_d;
    logic                   write_q, write_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BEATS_WIDTH-1:0] remaining_q, remaining_d;
    logic [OUT_W-1:0]       outstanding_q, outstanding_d;

    logic [NR_REQ-1:0]      w_eligible;
    logic                   w_load_ok;
    logic                   w_found;
    logic [SRC_W-1:0]       w_winner;
    int                     w_idx;
    logic [8:0]             w_blen;
    logic [BEATS_WIDTH-1:0] w_rem_next;
    logic                   w_fifo_full;
    logic                   w_ax_valid;
    logic                   w_ax_hs;
    logic                   w_aw_hs;
    logic                   w_b_hs;
    meta_t                  w_meta_in;

`ifdef VLSU_CTRL_LDST_ORDER_EN
    assign w_load_ok = (outstanding_q == '0) && !(state_q == ST_ISSUE && write_q);
`else
    assign w_load_ok = 1'b1;
`endif

    assign w_eligible = req_valid_i & (req_store_i | {NR_REQ{w_load_ok}});

    // Round-robin search over eligible channels starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int i = 0; i < int'(NR_REQ); i++) begin
            w_idx = int'(ptr_q) + i;
            if (w_idx >= int'(NR_REQ)) w_idx = w_idx - int'(NR_REQ);
            if (!w_found && w_eligible[w_idx[SRC_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[SRC_W-1:0];
            end
        end
    end

    assign w_blen      = burst_len(32'(remaining_q), addr_q[11:0], BEAT_BYTES, MAX_BURST_BEATS);
    assign w_rem_next  = remaining_q - BEATS_WIDTH'(w_blen);
    assign w_ax_valid  = (state_q == ST_ISSUE) && !w_fifo_full &&
                         !(write_q && outstanding_q == OUT_W'(MAX_OUTSTANDING));
    assign w_ax_hs     = w_ax_valid && ax_ready_i;
    assign w_aw_hs     = w_ax_hs && write_q;
    assign w_b_hs      = b_valid_i && b_ready_o;

    assign w_meta_in.src   = META_SRC_W'(src_q);
    assign w_meta_in.write = write_q;
    assign w_meta_in.beats = w_blen;
    assign w_meta_in.last  = (32'(remaining_q) == 32'(w_blen));

    assign req_ready_o  = (state_q == ST_IDLE && w_found) ? (NR_REQ'(1) << w_winner) : '0;
    assign ax_valid_o   = w_ax_valid;
    assign ax_write_o   = write_q;
    assign ax_addr_o    = addr_q;
    assign ax_len_o     = (state_q == ST_ISSUE) ? 8'(w_blen - 9'd1) : 8'd0;
    assign ax_src_o     = src_q;
    assign b_ready_o    = (outstanding_q != '0);
    assign st_pending_o = (outstanding_q != '0);
    assign busy_o       = (state_q != ST_IDLE) || meta_valid_o || (outstanding_q != '0);

    // Request capture, burst walk and outstanding-store bookkeeping.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        src_d         = src_q;
        write_d       = write_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    src_d       = w_winner;
                    write_d     = req_store_i[w_winner];
                    addr_d      = req_addr_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
                    remaining_d = req_beats_i[int'(w_winner)*BEATS_WIDTH +: BEATS_WIDTH];
                    ptr_d       = (int'(w_winner) == int'(NR_REQ) - 1) ? '0 : w_winner + 1'b1;
                    if (remaining_d != '0) state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_ax_hs) begin
                    addr_d      = addr_q + ADDR_WIDTH'(w_blen) * ADDR_WIDTH'(BEAT_BYTES);
                    remaining_d = w_rem_next;
                    if (w_rem_next == '0) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        case ({w_aw_hs, w_b_hs})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State registers; reset discards any partially issued request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            src_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            src_q         <= src_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
        end
    end

    vlsu_meta_fifo #(
        .T     (meta_t),
        .DEPTH (META_DEPTH)
    ) u_meta_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_ax_hs),
        .data_i  (w_meta_in),
        .full_o  (w_fifo_full),
        .pop_i   (meta_ready_i),
        .valid_o (meta_valid_o),
        .data_o  (meta_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_vlsu_ctrl_machine_mc.sv
`default_nettype none
//============================================================================
// Module      : tb_vlsu_ctrl_machine_mc
// Description : Randomized bench for vlsu_ctrl_machine_mc with a
//               transaction-level reference model (burst lists, metadata
//               queue, outstanding-store count).
// Revision    : 1.0 - initial release
//============================================================================
module tb_vlsu_ctrl_machine_mc;
    import vlsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_store = '0;
    logic [63:0] req_addr  = '0;
    logic [31:0] req_beats = '0;
    logic        ax_valid;
    logic        ax_ready = 1'b0;
    logic        ax_write;
    logic [31:0] ax_addr;
    logic [7:0]  ax_len;
    logic [0:0]  ax_src;
    logic        meta_valid;
    logic        meta_ready = 1'b0;
    meta_t       meta;
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic        st_pending;
    logic        busy;

    vlsu_ctrl_machine_mc dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_store_i  (req_store),
        .req_addr_i   (req_addr),
        .req_beats_i  (req_beats),
        .ax_valid_o   (ax_valid),
        .ax_ready_i   (ax_ready),
        .ax_write_o   (ax_write),
        .ax_addr_o    (ax_addr),
        .ax_len_o     (ax_len),
        .ax_src_o     (ax_src),
        .meta_valid_o (meta_valid),
        .meta_ready_i (meta_ready),
        .meta_o       (meta),
        .b_valid_i    (b_valid),
        .b_ready_o    (b_ready),
        .st_pending_o (st_pending),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          beats;
        bit          write;
        int          src;
        bit          last;
    } burst_t;

    burst_t m_ax[$];
    burst_t m_meta[$];
    int     m_ptr;
    int     m_out;

    int total = 0;
    int bad   = 0;

    int p_valid, p_store, p_axr, p_mr, p_b;
    bit single_beat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Split one request into the bursts the spec's rules demand.
    task automatic add_request(input logic [31:0] a, input int beats, input bit wr, input int src);
        int r;
        int page_left;
        int bl;
        logic [31:0] cur;
        cur = a;
        r   = beats;
        while (r > 0) begin
            page_left = (4096 - int'(cur % 4096)) / 8;
            bl = r;
            if (bl > 256)       bl = 256;
            if (bl > page_left) bl = page_left;
            m_ax.push_back('{addr: cur, beats: bl, write: wr, src: src, last: (r == bl)});
            cur = cur + 32'(bl * 8);
            r   = r - bl;
        end
    endtask

    task automatic model_reset();
        m_ax.delete();
        m_meta.delete();
        m_ptr = 0;
        m_out = 0;
    endtask

    task automatic randomize_inputs();
        logic [31:0] a;
        int          bt;
        for (int c = 0; c < 2; c++) begin
            req_valid[c] = ($urandom_range(99) < p_valid);
            req_store[c] = ($urandom_range(99) < p_store);
            if ($urandom_range(3) == 0)
                a = {16'd0, 4'($urandom_range(15)), 12'd0} + 32'(4096 - 8 * $urandom_range(1, 40));
            else
                a = $urandom & 32'h000F_FFF8;
            if (single_beat) begin
                bt = 1;
            end else begin
                case ($urandom_range(7))
                    0:       bt = 0;
                    1, 2, 3: bt = $urandom_range(1, 4);
                    4, 5:    bt = $urandom_range(1, 63);
                    6:       bt = $urandom_range(200, 700);
                    default: bt = 1;
                endcase
            end
            req_addr[c*32 +: 32]  = a;
            req_beats[c*16 +: 16] = 16'(bt);
        end
        ax_ready   = ($urandom_range(99) < p_axr);
        meta_ready = ($urandom_range(99) < p_mr);
        b_valid    = ($urandom_range(99) < p_b);
    endtask

    task automatic check_and_update();
        int   w;
        int   idx;
        bit   load_ok;
        bit   exp_axv;
        logic [1:0] exp_rdy;
        burst_t hd;
`ifdef VLSU_CTRL_LDST_ORDER_EN
        load_ok = (m_out == 0);
`else
        load_ok = 1'b1;
`endif
        w = -1;
        if (m_ax.size() == 0) begin
            for (int k = 0; k < 2; k++) begin
                idx = (m_ptr + k) % 2;
                if (w < 0 && req_valid[idx] && (req_store[idx] || load_ok)) w = idx;
            end
        end
        exp_rdy = (w >= 0) ? (2'b01 << w) : 2'b00;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

        exp_axv = (m_ax.size() > 0) && (m_meta.size() < 4) &&
                  !(m_ax[0].write && m_out == 8);
        check("ax_valid", 64'(ax_valid), 64'(exp_axv));
        if (exp_axv && ax_valid) begin
            hd = m_ax[0];
            check("ax_addr",  64'(ax_addr),  64'(hd.addr));
            check("ax_len",   64'(ax_len),   64'(hd.beats - 1));
            check("ax_write", 64'(ax_write), 64'(hd.write));
            check("ax_src",   64'(ax_src),   64'(hd.src));
        end

        check("meta_valid", 64'(meta_valid), 64'(m_meta.size() != 0));
        if (m_meta.size() != 0 && meta_valid) begin
            hd = m_meta[0];
            check("meta_src",   64'(meta.src),   64'(hd.src));
            check("meta_write", 64'(meta.write), 64'(hd.write));
            check("meta_beats", 64'(meta.beats), 64'(hd.beats));
            check("meta_last",  64'(meta.last),  64'(hd.last));
        end
        check("b_ready",    64'(b_ready),    64'(m_out != 0));
        check("st_pending", 64'(st_pending), 64'(m_out != 0));
        check("busy", 64'(busy), 64'((m_ax.size() != 0) || (m_meta.size() != 0) || (m_out != 0)));

        // Advance the model by the handshakes of this cycle.
        if (m_meta.size() != 0 && meta_ready) void'(m_meta.pop_front());
        if (b_valid && m_out != 0) m_out--;
        if (exp_axv && ax_ready) begin
            hd = m_ax.pop_front();
            m_meta.push_back(hd);
            if (hd.write) m_out++;
        end
        if (w >= 0) begin
            m_ptr = (w + 1) % 2;
            add_request(req_addr[w*32 +: 32], int'(req_beats[w*16 +: 16]), req_store[w], w);
        end
    endtask

    task automatic cycle();
        randomize_inputs();
        #1;
        check_and_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_knobs(input int v, input int s, input int ar, input int mr, input int b, input bit sb);
        p_valid = v; p_store = s; p_axr = ar; p_mr = mr; p_b = b; single_beat = sb;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"},   64'(req_ready),  64'd0);
        check({tag, "_axv"},     64'(ax_valid),   64'd0);
        check({tag, "_metav"},   64'(meta_valid), 64'd0);
        check({tag, "_bready"},  64'(b_ready),    64'd0);
        check({tag, "_stpend"},  64'(st_pending), 64'd0);
        check({tag, "_busy"},    64'(busy),       64'd0);
    endtask

    initial begin
        int drain;
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_axaddr", 64'(ax_addr),  64'd0);
        check("rst_axlen",  64'(ax_len),   64'd0);
        check("rst_axwr",   64'(ax_write), 64'd0);
        check("rst_axsrc",  64'(ax_src),   64'd0);
        check("rst_meta",   64'(meta),     64'd0);
        @(negedge clk);
        rst = 1'b0;

        // General mixed traffic.
        set_knobs(50, 50, 70, 70, 50, 1'b0);
        repeat (1500) cycle();

        // Reset in the middle of traffic drops everything.
        set_knobs(100, 50, 30, 30, 30, 1'b0);
        repeat (40) cycle();
        rst = 1'b1;
        req_valid = '0;
        #1;
        check_idle_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Data controller stalls: metadata FIFO fills with single-beat loads.
        set_knobs(80, 0, 90, 5, 50, 1'b1);
        repeat (400) cycle();

        // B responses scarce: outstanding stores reach the limit.
        set_knobs(80, 100, 90, 90, 3, 1'b1);
        repeat (400) cycle();

        // Interleaved loads and stores with modest B traffic.
        set_knobs(70, 50, 80, 80, 20, 1'b0);
        repeat (800) cycle();

        // Drain with everything ready and no new requests.
        set_knobs(0, 0, 100, 100, 100, 1'b0);
        drain = 0;
        while ((m_ax.size() != 0 || m_meta.size() != 0 || m_out != 0) && drain < 5000) begin
            cycle();
            drain++;
        end
        check("drain_done", 64'(m_ax.size() + m_meta.size() + m_out), 64'd0);
        #1;
        check("busy_end", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
